polyphase_serializer: RTL and testbench

POLYPHASE_SERIALIZER -- requirements
Module: polyphase_serializer

---
 rtl/polyphase_serializer.sv | 120 ++++++++++++
 tb/tb_polyphase_serializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_serializer.sv
// polyphase_serializer: converts a parallel frame of gp_nr_stages signed samples into a serial
// stream, slot 0 first, emitting one sample per cycle in which i_ena is high.
// Latency: a handshake (i_valid & o_ready) in cycle t gives the first o_valid in cycle t+2 when i_ena stays high.
// Backpressure: o_ready is high in IDLE, and in SHIFT only on the last-slot emission cycle,
//               so back-to-back frames run gaplessly. i_ena low stalls the shifter in place.
//
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_ena           output-rate strobe
//   i_valid/i_data  parallel frame input; slot k = i_data[(k+1)*W-1 -: W]
//   o_ready         frame accepted on this cycle's edge when i_valid is also high
//   o_data/o_valid  serial sample and its one-cycle strobe
//   o_shift_done    sticky: at least one complete frame has been emitted
//   o_underrun      one-cycle pulse: i_ena high while idle, after the first frame

module polyphase_serializer #(
  parameter int gp_data_width = 8,
  parameter int gp_nr_stages  = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_ena,
  input  logic                                    i_valid,
  input  logic [gp_nr_stages*gp_data_width-1:0]  i_data,
  output logic                                    o_ready,
  output logic signed [gp_data_width-1:0]         o_data,
  output logic                                    o_valid,
  output logic                                    o_shift_done,
  output logic                                    o_underrun
);

  localparam int                  LP_CNT_W = $clog2(gp_nr_stages);
  localparam logic [LP_CNT_W-1:0] LP_LAST  = LP_CNT_W'(gp_nr_stages - 1);
  localparam logic [LP_CNT_W-1:0] LP_ONE   = LP_CNT_W'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]                               r_state;
  logic [LP_CNT_W-1:0]                      r_cnt;
  logic [gp_nr_stages*gp_data_width-1:0]    r_frame;
  logic signed [gp_data_width-1:0]          r_data;
  logic                                     r_valid;
  logic                                     r_shift_done;
  logic                                     r_underrun;

  logic                                     w_idle;
  logic                                     w_emit;
  logic                                     w_last;
  logic                                     w_ready;
  logic                                     w_capture;
  logic [gp_data_width-1:0]                 w_slots [gp_nr_stages];
  logic [gp_data_width-1:0]                 w_slot;

  // Split the frame register into slots so the counter can index directly.
  for (genvar g = 0; g < gp_nr_stages; g++) begin : g_slot
    assign w_slots[g] = r_frame[g*gp_data_width +: gp_data_width];
  end

  assign w_slot    = w_slots[r_cnt];
  assign w_idle    = (r_state == ST_IDLE);
  assign w_emit    = (r_state == ST_SHIFT) && i_ena;
  assign w_last    = w_emit && (r_cnt == LP_LAST);
  // Accepting on the last-slot emission lets the next frame follow with no idle slot.
  assign w_ready   = w_idle || w_last;
  assign w_capture = i_valid && w_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_frame      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_shift_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      // An idle output slot only counts as an underrun once the stream has started.
      r_underrun <= w_idle && i_ena && r_shift_done;

      if (w_capture) begin
        r_frame <= i_data;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          if (i_ena) begin
            r_data  <= w_slot;
            r_valid <= 1'b1;
            if (r_cnt == LP_LAST) begin
              r_cnt        <= '0;
              r_shift_done <= 1'b1;
              r_state      <= w_capture ? ST_SHIFT : ST_IDLE;
            end else begin
              r_cnt <= r_cnt + LP_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_ready      = w_ready;
  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_shift_done = r_shift_done;
  assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_polyphase_serializer.sv
module tb_polyphase_serializer;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        valid;
  logic [31:0] data;
  logic        ready;
  logic [7:0]  odata;
  logic        ovalid;
  logic        sdone;
  logic        urun;

  int          n_vec;
  int          n_err;
  int          n_urun;
  logic [7:0]  last_data;
  logic [7:0]  exp_q[$];

  polyphase_serializer #(
    .gp_data_width(8),
    .gp_nr_stages (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ena       (ena),
    .i_valid     (valid),
    .i_data      (data),
    .o_ready     (ready),
    .o_data      (odata),
    .o_valid     (ovalid),
    .o_shift_done(sdone),
    .o_underrun  (urun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every o_valid pops one expected sample; between strobes o_data must hold.
  initial begin
    logic [7:0] e;
    last_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last_data = 8'h00;
      end else begin
        n_vec++;
        if (ovalid) begin
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_valid: o_data=%h while nothing expected", odata);
          end else begin
            e = exp_q.pop_front();
            if (odata !== e) begin
              n_err++;
              $display("FAIL sample: o_data=%h expected=%h", odata, e);
            end
          end
          last_data = odata;
        end else if (odata !== last_data) begin
          n_err++;
          $display("FAIL hold: o_data=%h expected held %h", odata, last_data);
        end
        if (urun) n_urun++;
      end
    end
  end

  task automatic push_frame(input logic [31:0] f);
    for (int s = 0; s < 4; s++) begin
      logic [31:0] t;
      t = f >> (8 * s);
      exp_q.push_back(t[7:0]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; ena = 1'b0; valid = 1'b0; data = '0;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (odata !== 8'h00) begin n_err++; $display("FAIL rst_odata: got %h want 00", odata); end
    n_vec++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL rst_ovalid: got %b want 0", ovalid); end
    n_vec++; if (sdone !== 1'b0) begin n_err++; $display("FAIL rst_sdone: got %b want 0", sdone); end
    n_vec++; if (urun !== 1'b0) begin n_err++; $display("FAIL rst_urun: got %b want 0", urun); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", ready); end
  endtask

  task automatic test_idle_ena;
    int u0;
    u0 = n_urun;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) ena = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", ovalid); end
      n_vec++; if (urun !== 1'b0) begin n_err++; $display("FAIL idle_urun: got %b want 0", urun); end
      n_vec++; if (sdone !== 1'b0) begin n_err++; $display("FAIL idle_sdone: got %b want 0", sdone); end
    end
    @(negedge clk) ena = 1'b0;
    #1;
    n_vec++; if (n_urun != u0) begin n_err++; $display("FAIL idle_urun_count: got %0d want 0", n_urun - u0); end
  endtask

  task automatic test_basic;
    @(negedge clk);
    valid = 1'b1; data = 32'h04030201; ena = 1'b1;
    push_frame(32'h04030201);
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_idle: got %b want 1", ready); end
    @(posedge clk); #1;
    n_vec++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL basic_capture_cycle: o_valid=%b want 0", ovalid); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) valid = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (ovalid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d]: got %b want 1", k, ovalid); end
      n_vec++; if (sdone !== (k == 4)) begin n_err++; $display("FAIL basic_sdone[%0d]: got %b want %b", k, sdone, (k == 4)); end
    end
    @(negedge clk) ena = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL basic_after: o_valid=%b want 0", ovalid); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_after: got %b want 1", ready); end
  endtask

  task automatic test_alternate;
    int u0;
    logic ev;
    u0 = n_urun;
    @(negedge clk);
    valid = 1'b1; data = 32'h44332211; ena = 1'b0;
    push_frame(32'h44332211);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      valid = 1'b0;
      ena = (k % 2 == 1);
      @(posedge clk); #1;
      ev = (k % 2 == 1);
      n_vec++; if (ovalid !== ev) begin n_err++; $display("FAIL alt_valid[%0d]: got %b want %b", k, ovalid, ev); end
      if (k % 2 == 0) begin
        n_vec++;
        if (odata !== 8'(8'h11 * (k / 2))) begin
          n_err++; $display("FAIL alt_hold[%0d]: got %h want %h", k, odata, 8'(8'h11 * (k / 2)));
        end
      end
    end
    @(negedge clk) ena = 1'b0;
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL alt_ready_end: got %b want 1", ready); end
    n_vec++; if (n_urun != u0) begin n_err++; $display("FAIL alt_urun_count: got %0d want 0", n_urun - u0); end
  endtask

  task automatic test_back_to_back;
    int   u0;
    logic er;
    u0 = n_urun;
    @(negedge clk);
    valid = 1'b1; data = 32'hF1E2D3C4; ena = 1'b0;
    push_frame(32'hF1E2D3C4);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        data = 32'h0B1A2938; ena = 1'b1;
        push_frame(32'h0B1A2938);
      end
      if (k == 5) valid = 1'b0;
      #1;
      er = (k == 4) || (k == 8);
      n_vec++; if (ready !== er) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, ready, er); end
      @(posedge clk); #1;
      n_vec++; if (ovalid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, ovalid); end
    end
    @(negedge clk) ena = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL b2b_after: o_valid=%b want 0", ovalid); end
    n_vec++; if (n_urun != u0) begin n_err++; $display("FAIL b2b_urun_count: got %0d want 0", n_urun - u0); end
  endtask

  task automatic test_underrun;
    int u0;
    u0 = n_urun;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      ena = 1'b1; valid = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (urun !== 1'b1) begin n_err++; $display("FAIL urun_pulse[%0d]: got %b want 1", k, urun); end
      n_vec++; if (odata !== 8'h0B) begin n_err++; $display("FAIL urun_hold[%0d]: got %h want 0b", k, odata); end
      n_vec++; if (sdone !== 1'b1) begin n_err++; $display("FAIL urun_sdone[%0d]: got %b want 1", k, sdone); end
    end
    @(negedge clk) ena = 1'b0;
    @(posedge clk); #2;
    n_vec++; if (urun !== 1'b0) begin n_err++; $display("FAIL urun_stop: got %b want 0", urun); end
    n_vec++; if (n_urun - u0 != 3) begin n_err++; $display("FAIL urun_count: got %0d want 3", n_urun - u0); end
  endtask

  task automatic test_reset_mid;
    bit found;
    @(negedge clk);
    valid = 1'b1; data = 32'h77665544; ena = 1'b0;
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    @(posedge clk);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      valid = 1'b0; ena = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (ovalid !== 1'b1) begin n_err++; $display("FAIL mid_valid[%0d]: got %b want 1", k, ovalid); end
    end
    @(negedge clk) rst = 1'b1;
    #1;
    n_vec++; if (odata !== 8'h00) begin n_err++; $display("FAIL mid_rst_odata: got %h want 00", odata); end
    n_vec++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovalid: got %b want 0", ovalid); end
    n_vec++; if (sdone !== 1'b0) begin n_err++; $display("FAIL mid_rst_sdone: got %b want 0", sdone); end
    n_vec++; if (urun !== 1'b0) begin n_err++; $display("FAIL mid_rst_urun: got %b want 0", urun); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_rel_ready: got %b want 1", ready); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_pending: got %0d queued want 0", exp_q.size()); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_vec++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL mid_stale[%0d]: o_valid=%b want 0", k, ovalid); end
      n_vec++; if (urun !== 1'b0) begin n_err++; $display("FAIL mid_urun[%0d]: got %b want 0", k, urun); end
    end
    @(negedge clk);
    valid = 1'b1; data = 32'hDDCCBBAA; ena = 1'b1;
    push_frame(32'hDDCCBBAA);
    @(posedge clk); #1;
    @(negedge clk) valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk); #1;
      if (ovalid) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL mid_first_timeout: o_valid=%b want 1", ovalid); end
    n_vec++; if (odata !== 8'hAA) begin n_err++; $display("FAIL mid_first: got %h want aa", odata); end
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk) ena = 1'b0;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_drain: got %0d queued want 0", exp_q.size()); end
    n_vec++; if (sdone !== 1'b1) begin n_err++; $display("FAIL mid_sdone: got %b want 1", sdone); end
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_urun = 0;
    test_reset;
    test_idle_ena;
    test_basic;
    test_alternate;
    test_back_to_back;
    test_underrun;
    test_reset_mid;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL final_queue: got %0d queued want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
